usb_in_sched: RTL and testbench

IN-transaction scheduler for the low-speed USB device. It sits beside `usb_sie` on the transceiver transmit port and answers IN tokens for endpoints 0…num_endp-1. It chooses the response (DATA0/DATA1 packet, NAK or STALL), fetches payload bytes from the selected endpoint, appends CRC16 and tracks the per-endpoint data toggle from the host handshake.

---
 rtl/usb_in_sched_pkg.sv | 42 ++++
 rtl/usb_in_sched.sv | 190 +++++++++++++++++++
 tb/tb_usb_in_sched.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_in_sched_pkg.sv
// Shared USB packet types, PID encoding and the byte-wise CRC16 step.
// Pure definitions: no latency, no flow control.
package usb_in_sched_pkg;

    localparam logic [15:0] crc16_poly = 16'ha001;
    localparam logic [15:0] CRC16_INIT = 16'hffff;

    typedef enum logic [3:0] {
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI,
        S_WAIT_HS,
        S_HSK
    } state_t;

    // PID byte on the wire carries the check nibble in the upper half.
    function automatic logic [7:0] tx_pid(input pid_t p);
        logic [3:0] v;
        v = p;
        return {~v, v};
    endfunction

    function automatic logic [15:0] step_crc16(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ b[i]) ? ((c >> 1) ^ crc16_poly) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_in_sched.sv
// IN-token responder: DATA0/1 + CRC16, NAK or STALL; PID one cycle after tok_in.
// Advances one byte per tx_ready pulse; ep_rd is decoded in the tx_ready cycle.
module usb_in_sched
    import usb_in_sched_pkg::*;
#(
    parameter int num_endp = 1,
    parameter int max_len  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tok_in,
    input  logic                     tok_setup,
    input  logic [3:0]               tok_endp,
    input  logic                     hs_ack,
    input  logic                     hs_timeout,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [num_endp-1:0][3:0] ep_len,
    input  logic [num_endp-1:0]      ep_pend,
    input  logic [num_endp-1:0]      ep_stall,
    input  logic [num_endp-1:0][7:0] ep_data,
    output logic [num_endp-1:0]      ep_rd,
    output logic [num_endp-1:0]      ep_done,
    output logic [num_endp-1:0]      ep_retry
);

    state_t                state_q;
    logic [1:0]            endp_q;
    logic [3:0]            cnt_q;
    logic [15:0]           crc_q;
    logic [num_endp-1:0]   toggle_q;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;
    logic [num_endp-1:0]   done_q;
    logic [num_endp-1:0]   retry_q;
    logic                  held_q;
    logic [3:0]            held_endp_q;

    logic [3:0][7:0]       data_x;
    logic [3:0][3:0]       len_x;
    logic [3:0]            pend_x;
    logic [3:0]            stall_x;
    logic [3:0]            tog_x;
    logic                  tok_go;
    logic [3:0]            tok_ep;
    logic [1:0]            ep_sel;
    logic [7:0]            cur_byte;
    logic [15:0]           crc_d;
    logic [3:0]            len_clip;

    // Endpoint vectors padded to four entries so a 2-bit index never runs off the end.
    always_comb begin
        data_x  = '0;
        len_x   = '0;
        pend_x  = '0;
        stall_x = '0;
        tog_x   = '0;
        for (int i = 0; i < num_endp; i++) begin
            data_x[i]  = ep_data[i];
            len_x[i]   = ep_len[i];
            pend_x[i]  = ep_pend[i];
            stall_x[i] = ep_stall[i];
            tog_x[i]   = toggle_q[i];
        end
    end

    always_comb begin
        tok_go   = tok_in | held_q;
        tok_ep   = held_q ? held_endp_q : tok_endp;
        ep_sel   = tok_ep[1:0];
        cur_byte = data_x[endp_q];
        crc_d    = step_crc16(crc_q, cur_byte);
        len_clip = (len_x[ep_sel] > 4'(max_len)) ? 4'(max_len) : len_x[ep_sel];
    end

    // FWFT payload: the byte goes straight out and the read strobe fires with its accept.
    always_comb begin
        ep_rd = '0;
        for (int i = 0; i < num_endp; i++) begin
            ep_rd[i] = !reset && (state_q == S_DATA) && tx_ready && (endp_q == 2'(i));
        end
    end

    assign tx_data  = (state_q == S_DATA) ? cur_byte : tx_data_q;
    assign tx_valid = tx_valid_q;
    assign ep_done  = done_q;
    assign ep_retry = retry_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            endp_q      <= '0;
            cnt_q       <= '0;
            crc_q       <= CRC16_INIT;
            toggle_q    <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            done_q      <= '0;
            retry_q     <= '0;
            held_q      <= 1'b0;
            held_endp_q <= '0;
        end else begin
            done_q  <= '0;
            retry_q <= '0;
            case (state_q)
                S_IDLE: begin
                    held_q <= 1'b0;
                    crc_q  <= CRC16_INIT;
                    if (tok_go && (tok_ep < 4'(num_endp))) begin
                        endp_q     <= ep_sel;
                        tx_valid_q <= 1'b1;
                        if (stall_x[ep_sel]) begin
                            tx_data_q <= tx_pid(PID_STALL);
                            state_q   <= S_HSK;
                        end else if (!pend_x[ep_sel]) begin
                            tx_data_q <= tx_pid(PID_NAK);
                            state_q   <= S_HSK;
                        end else begin
                            tx_data_q <= tx_pid(tog_x[ep_sel] ? PID_DATA1 : PID_DATA0);
                            cnt_q     <= len_clip;
                            state_q   <= S_PID;
                        end
                    end
                end
                S_HSK, S_CRC_HI: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                        state_q    <= (state_q == S_HSK) ? S_IDLE : S_WAIT_HS;
                    end
                end
                S_PID: begin
                    if (tx_ready) begin
                        if (cnt_q != 4'd0) begin
                            tx_data_q <= '0;
                            state_q   <= S_DATA;
                        end else begin
                            tx_data_q <= ~crc_q[7:0];
                            state_q   <= S_CRC_LO;
                        end
                    end
                end
                S_DATA: begin
                    if (tx_ready) begin
                        crc_q <= crc_d;
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            tx_data_q <= ~crc_d[7:0];
                            state_q   <= S_CRC_LO;
                        end
                    end
                end
                S_CRC_LO: begin
                    if (tx_ready) begin
                        tx_data_q <= ~crc_q[15:8];
                        state_q   <= S_CRC_HI;
                    end
                end
                S_WAIT_HS: begin
                    // A token that ends the wait is replayed from IDLE next cycle.
                    if (tok_in) begin
                        held_q      <= 1'b1;
                        held_endp_q <= tok_endp;
                    end
                    if (hs_ack) begin
                        for (int i = 0; i < num_endp; i++) begin
                            if (endp_q == 2'(i)) begin
                                toggle_q[i] <= ~toggle_q[i];
                                done_q[i]   <= 1'b1;
                            end
                        end
                        state_q <= S_IDLE;
                    end else if (hs_timeout || tok_in || tok_setup) begin
                        for (int i = 0; i < num_endp; i++) begin
                            if (endp_q == 2'(i)) retry_q[i] <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // SETUP forces DATA1 for the next data stage and overrides an ACK flip.
            for (int i = 0; i < num_endp; i++) begin
                if (tok_setup && (tok_endp == 4'(i))) toggle_q[i] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_in_sched.sv
// Directed plus randomized bench for usb_in_sched against a packet-level reference model.
module tb_usb_in_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            tok_in;
    logic            tok_setup;
    logic [3:0]      tok_endp;
    logic            hs_ack;
    logic            hs_timeout;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [0:0][3:0] ep_len;
    logic [0:0]      ep_pend;
    logic [0:0]      ep_stall;
    logic [0:0][7:0] ep_data;
    logic [0:0]      ep_rd;
    logic [0:0]      ep_done;
    logic [0:0]      ep_retry;

    logic [7:0] pay [16];
    int         rdptr  = 0;
    int         rd_tot = 0;
    int         n_cmp  = 0;
    int         n_bad  = 0;
    bit         tog;
    logic [7:0] got   [$];
    logic [7:0] exp_q [$];

    usb_in_sched #(.num_endp(1), .max_len(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .tok_in     (tok_in),
        .tok_setup  (tok_setup),
        .tok_endp   (tok_endp),
        .hs_ack     (hs_ack),
        .hs_timeout (hs_timeout),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ep_len     (ep_len),
        .ep_pend    (ep_pend),
        .ep_stall   (ep_stall),
        .ep_data    (ep_data),
        .ep_rd      (ep_rd),
        .ep_done    (ep_done),
        .ep_retry   (ep_retry)
    );

    // Endpoint buffer: first-word-fall-through, rewound on retry/done/reset.
    assign ep_data[0] = pay[rdptr[3:0]];
    always @(posedge clk) begin
        if (reset || ep_done[0] || ep_retry[0]) rdptr <= 0;
        else if (ep_rd[0]) rdptr <= rdptr + 1;
        if (ep_rd[0]) rd_tot <= rd_tot + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // CRC16 over the payload as one LSB-first bit stream.
    function automatic logic [15:0] ref_crc(input int len);
        logic [15:0] r;
        bit fb;
        r = 16'hffff;
        for (int i = 0; i < len * 8; i++) begin
            fb = r[0] ^ pay[i / 8][i % 8];
            r  = {1'b0, r[15:1]} ^ (fb ? 16'ha001 : 16'h0000);
        end
        return r;
    endfunction

    task automatic build_exp(input bit p, input bit s, input int len);
        logic [15:0] c;
        exp_q.delete();
        if (s) exp_q.push_back(8'h1e);
        else if (!p) exp_q.push_back(8'h5a);
        else begin
            exp_q.push_back(tog ? 8'h4b : 8'hc3);
            for (int i = 0; i < len; i++) exp_q.push_back(pay[i]);
            c = ~ref_crc(len);
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end
    endtask

    task automatic recv();
        int guard;
        guard = 0;
        got.delete();
        while (tx_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        while (tx_valid === 1'b1 && got.size() < 20) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            got.push_back(tx_data);
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
    endtask

    task automatic rx_check(input bit p, input bit s, input int len, input string tag);
        int rd0;
        rd0 = rd_tot;
        build_exp(p, s, len);
        recv();
        chk({tag, "_nbytes"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk({tag, "_byte"}, got[i], exp_q[i]);
        chk({tag, "_nrd"}, rd_tot - rd0, (p && !s) ? len : 0);
    endtask

    task automatic send_in(input logic [3:0] e);
        tok_endp = e;
        tok_in   = 1'b1;
        @(negedge clk);
        tok_in   = 1'b0;
    endtask

    task automatic send_setup();
        tok_endp  = 4'd0;
        tok_setup = 1'b1;
        @(negedge clk);
        tok_setup = 1'b0;
        tog       = 1'b1;
    endtask

    task automatic xact(input bit p, input bit s, input int len, input string tag);
        ep_pend[0]  = p;
        ep_stall[0] = s;
        ep_len[0]   = 4'(len);
        send_in(4'd0);
        build_exp(p, s, len);
        chk({tag, "_lat_vld"}, tx_valid, 1);
        chk({tag, "_lat_pid"}, tx_data, exp_q[0]);
        rx_check(p, s, len, tag);
    endtask

    // kind: 0 ack, 1 timeout, 2 ack+timeout, 3 new IN token
    task automatic hs(input int kind, input string tag);
        bit acked;
        acked      = (kind == 0 || kind == 2);
        hs_ack     = acked;
        hs_timeout = (kind == 1 || kind == 2);
        if (kind == 3) begin
            tok_endp = 4'd0;
            tok_in   = 1'b1;
        end
        @(negedge clk);
        hs_ack     = 1'b0;
        hs_timeout = 1'b0;
        tok_in     = 1'b0;
        chk({tag, "_done"}, ep_done[0], acked);
        chk({tag, "_retry"}, ep_retry[0], !acked);
        if (acked) tog = ~tog;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; tok_in = 1'b0; tok_setup = 1'b0; tok_endp = '0;
        hs_ack = 1'b0; hs_timeout = 1'b0; tx_ready = 1'b0;
        ep_len = '0; ep_pend = '0; ep_stall = '0;
        for (int j = 0; j < 16; j++) pay[j] = 8'(j);
        tog = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_txv", tx_valid, 0);
        chk("rst_txd", tx_data, 0);
        chk("rst_done", ep_done, 0);
        chk("rst_retry", ep_retry, 0);
        chk("rst_rd", ep_rd, 0);

        xact(1, 0, 0, "zlp");
        hs(0, "zlp_hs");
        xact(1, 0, 0, "zlp_d1");
        hs(0, "zlp_d1_hs");

        xact(1, 0, 4, "p4");
        hs(1, "p4_to");
        xact(1, 0, 4, "p4_rtx");
        hs(0, "p4_ack");

        xact(0, 0, 4, "nak");
        xact(1, 1, 4, "stall");

        xact(1, 0, 1, "pre_setup");
        hs(0, "pre_setup_hs");
        send_setup();
        xact(1, 0, 2, "setup");
        hs(1, "setup_to");

        // Reset in the middle of the payload.
        ep_pend[0] = 1'b1; ep_stall[0] = 1'b0; ep_len[0] = 4'd6;
        send_in(4'd0);
        repeat (2) begin
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_txv", tx_valid, 0);
        chk("midrst_done", ep_done, 0);
        chk("midrst_retry", ep_retry, 0);
        @(negedge clk);
        chk("midrst_done2", ep_done, 0);
        chk("midrst_retry2", ep_retry, 0);
        tog = 1'b0;
        xact(1, 0, 0, "post_rst");
        hs(0, "post_rst_hs");

        send_in(4'd3);
        for (int j = 0; j < 4; j++) begin
            chk("range_txv", tx_valid, 0);
            @(negedge clk);
        end

        for (int it = 0; it < 25; it++) begin
            bit p;
            bit s;
            int l;
            int k;
            p = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 5) == 0);
            l = $urandom_range(0, 8);
            for (int j = 0; j < 16; j++) pay[j] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) send_setup();
            xact(p, s, l, "rnd");
            if (p && !s) begin
                k = $urandom_range(0, 3);
                hs(k, "rnd_hs");
                if (k == 3) begin
                    rx_check(p, s, l, "rnd_reeval");
                    hs(0, "rnd_hs2");
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
